// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the lab datapath: accepts one instruction over
// valid/ready, then steps the datapath through read, execute and write-back cycles.
module datapath_sequencer (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [2:0]  readnum,
   output logic        loada,
   output logic        loadb,
   output logic [1:0]  shift,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  ALUop,
   output logic        loadc,
   output logic        loads,
   output logic [2:0]  writenum,
   output logic        vsel,
   output logic        write,
   output logic [15:0] datapath_in,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_WB_REG,
      S_WB_IMM,
      S_BAD
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [15:0] r_instr;
   logic        w_accept;
   logic [2:0]  w_opc;
   logic [1:0]  w_op;
   logic [2:0]  w_rn;
   logic [2:0]  w_rd;
   logic [1:0]  w_sh;
   logic [2:0]  w_rm;
   logic [7:0]  w_imm8;
   logic        w_isCmp;
   logic        w_isMovReg;

   assign w_accept   = instr_valid && (r_state == S_IDLE);
   assign w_opc      = r_instr[15:13];
   assign w_op       = r_instr[12:11];
   assign w_rn       = r_instr[10:8];
   assign w_rd       = r_instr[7:5];
   assign w_sh       = r_instr[4:3];
   assign w_rm       = r_instr[2:0];
   assign w_imm8     = r_instr[7:0];
   assign w_isCmp    = (w_opc == 3'b101) && (w_op == 2'b01);
   assign w_isMovReg = (w_opc == 3'b110);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_instr <= 16'h0000;
      end else begin
         r_state <= w_nextState;
         if (w_accept)
            r_instr <= instr;
      end
   end

   // Dispatch decodes the incoming word directly; later states use the latched copy.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (instr[15:11])
                  5'b110_10:                     w_nextState = S_WB_IMM;
                  5'b110_00:                     w_nextState = S_GET_B;
                  5'b101_00, 5'b101_01, 5'b101_10: w_nextState = S_GET_A;
                  5'b101_11:                     w_nextState = S_GET_B;
                  default:                       w_nextState = S_BAD;
               endcase
            end
         end
         S_GET_A: w_nextState = S_GET_B;
         S_GET_B: w_nextState = S_EXEC;
         S_EXEC:  w_nextState = w_isCmp ? S_IDLE : S_WB_REG;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = 1'b0;
      readnum     = 3'd0;
      loada       = 1'b0;
      loadb       = 1'b0;
      shift       = 2'b00;
      asel        = 1'b0;
      bsel        = 1'b0;
      ALUop       = 2'b00;
      loadc       = 1'b0;
      loads       = 1'b0;
      writenum    = 3'd0;
      vsel        = 1'b0;
      write       = 1'b0;
      datapath_in = 16'h0000;
      done        = 1'b0;
      err         = 1'b0;
      case (r_state)
         S_IDLE: instr_ready = 1'b1;
         S_GET_A: begin
            readnum = w_rn;
            loada   = 1'b1;
         end
         S_GET_B: begin
            readnum = w_rm;
            loadb   = 1'b1;
         end
         S_EXEC: begin
            shift = w_sh;
            if (w_isMovReg) begin
               asel  = 1'b1;
               ALUop = 2'b00;
               loadc = 1'b1;
            end else if (w_isCmp) begin
               ALUop = 2'b01;
               loads = 1'b1;
               done  = 1'b1;
            end else begin
               ALUop = w_op;
               loadc = 1'b1;
            end
         end
         S_WB_REG: begin
            writenum = w_rd;
            write    = 1'b1;
            done     = 1'b1;
         end
         S_WB_IMM: begin
            writenum    = w_rn;
            vsel        = 1'b1;
            write       = 1'b1;
            datapath_in = {{8{w_imm8[7]}}, w_imm8};
            done        = 1'b1;
         end
         S_BAD: begin
            err  = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
